// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS pipeline data-memory path.
//   WORD_W       : datapath width (32)
//   SZ_BYTE/HALF/WORD : MEM_size encodings (2'b11 is reserved and behaves as a word)
//   mem_state_t  : access FSM states (IDLE, BUSY)
package mips_pkg;

   localparam int WORD_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

endpackage

// File: rtl/mem_lane_format.sv
// mem_lane_format
// Purely combinational lane handling for the data memory.
// Ports:
//   addr_lo    in  2   byte lane of the access (address bits [1:0])
//   size       in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD, 11 = word)
//   signext    in  1   sign-extend sub-word loads when 1
//   store_data in  32  right-justified store data
//   ram_word   in  32  word currently addressed in the RAM
//   byte_en    out 4   per-lane write enables
//   wdata      out 32  store data replicated onto every lane it may land in
//   load_data  out 32  extracted and extended load value
//   misalign   out 1   address not naturally aligned for the access size
// Misaligned halfwords/words are force-aligned here; the top decides whether
// to trap on them.
import mips_pkg::*;

module mem_lane_format (
   input  logic [1:0]        addr_lo,
   input  logic [1:0]        size,
   input  logic              signext,
   input  logic [WORD_W-1:0] store_data,
   input  logic [WORD_W-1:0] ram_word,
   output logic [3:0]        byte_en,
   output logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] load_data,
   output logic              misalign
);

   logic [1:0]        lane;
   logic [WORD_W-1:0] shifted;

   // Pick the effective lane, then derive write enables and load extraction.
   // Store data is replicated so the enabled lanes always carry the right bytes.
   always_comb begin
      lane      = 2'b00;
      byte_en   = 4'b1111;
      wdata     = store_data;
      misalign  = 1'b0;
      load_data = ram_word;
      shifted   = ram_word;

      case (size)
         SZ_BYTE: begin
            lane    = addr_lo;
            byte_en = 4'b0001 << lane;
            wdata   = {4{store_data[7:0]}};
         end
         SZ_HALF: begin
            lane     = {addr_lo[1], 1'b0};
            byte_en  = 4'b0011 << lane;
            wdata    = {2{store_data[15:0]}};
            misalign = addr_lo[0];
         end
         default: begin
            lane     = 2'b00;
            byte_en  = 4'b1111;
            wdata    = store_data;
            misalign = |addr_lo;
         end
      endcase

      shifted = ram_word >> {lane, 3'b000};

      case (size)
         SZ_BYTE: load_data = {{24{signext & shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_data = {{16{signext & shifted[15]}}, shifted[15:0]};
         default: load_data = ram_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage data memory of the 5-stage MIPS pipeline. Performs byte/halfword/
// word loads and stores on an internal word-addressed RAM over LATENCY cycles
// and stalls the pipeline while an access is in flight.
// Ports:
//   clk            in  1   pipeline clock
//   reset          in  1   synchronous, active-high
//   MEM_aluout     in  32  byte address (wraps modulo DEPTH*4)
//   MEM_writedata  in  32  store data, right-justified
//   MEM_memread    in  1   load request
//   MEM_memwrite   in  1   store request (wins over a simultaneous load)
//   MEM_size       in  2   00 byte, 01 half, 10/11 word
//   MEM_signext    in  1   sign-extend sub-word loads
//   MEM_memout     out 32  formatted load data, 0 unless a load completes
//   mem_stall      out 1   hold the front of the pipeline
//   mem_misalign   out 1   misaligned access on its completion cycle
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When defined, misaligned
// accesses flag mem_misalign, stores are suppressed and loads return 0.
// Otherwise mem_misalign is 0 and addresses are force-aligned.
import mips_pkg::*;

module mem_access_unit #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] MEM_aluout,
   input  logic [WORD_W-1:0] MEM_writedata,
   input  logic              MEM_memread,
   input  logic              MEM_memwrite,
   input  logic [1:0]        MEM_size,
   input  logic              MEM_signext,
   output logic [WORD_W-1:0] MEM_memout,
   output logic              mem_stall,
   output logic              mem_misalign
);

   localparam int AW = $clog2(DEPTH);

`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic [WORD_W-1:0] ram [DEPTH];

   logic              req;
   logic              complete;
   logic              trap;
   logic [AW-1:0]     word_idx;
   logic [WORD_W-1:0] ram_word;
   logic [3:0]        byte_en;
   logic [WORD_W-1:0] wdata;
   logic [WORD_W-1:0] load_data;
   logic              misalign;
   logic              unused_addr_hi;

   assign req            = MEM_memread | MEM_memwrite;
   assign word_idx       = MEM_aluout[AW+1:2];
   assign unused_addr_hi = ^MEM_aluout[WORD_W-1:AW+2];
   assign ram_word       = ram[word_idx];

   mem_lane_format u_fmt (
      .addr_lo    (MEM_aluout[1:0]),
      .size       (MEM_size),
      .signext    (MEM_signext),
      .store_data (MEM_writedata),
      .ram_word   (ram_word),
      .byte_en    (byte_en),
      .wdata      (wdata),
      .load_data  (load_data),
      .misalign   (misalign)
   );

   generate
      if (LATENCY >= 2) begin : g_fsm
         mem_state_t state;
         logic [3:0] count;

         // The request cycle in IDLE already stands for the first step of the
         // countdown, so BUSY starts one below LATENCY-1 and completes at 0.
         // That gives LATENCY-1 stall cycles and LATENCY cycles per access.
         always_ff @(posedge clk) begin
            if (reset) begin
               state <= IDLE;
               count <= 4'd0;
            end else begin
               case (state)
                  IDLE: begin
                     if (req) begin
                        state <= BUSY;
                        count <= 4'(LATENCY - 2);
                     end
                  end
                  BUSY: begin
                     if (count == 4'd0) begin
                        state <= IDLE;
                     end else begin
                        count <= count - 4'd1;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end

         assign complete  = (state == BUSY) && (count == 4'd0);
         assign mem_stall = ((state == IDLE) && req) ||
                            ((state == BUSY) && (count != 4'd0));
      end else begin : g_single
         // LATENCY 0 or 1: every request completes in the cycle it appears.
         assign complete  = req;
         assign mem_stall = 1'b0;
      end
   endgenerate

   assign trap         = TRAP_EN & misalign;
   assign mem_misalign = complete & trap;
   assign MEM_memout   = (complete && MEM_memread && !MEM_memwrite && !trap) ?
                         load_data : '0;

   // Store commits at the edge closing the completion cycle. A reset in that
   // cycle discards it; the RAM itself is never cleared by reset.
   always_ff @(posedge clk) begin
      if (complete && MEM_memwrite && !trap && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               ram[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed bench for mem_access_unit with DEPTH = 1024, LATENCY = 2.
module tb_mem_access_unit;

   logic        clk;
   logic        reset;
   logic [31:0] MEM_aluout;
   logic [31:0] MEM_writedata;
   logic        MEM_memread;
   logic        MEM_memwrite;
   logic [1:0]  MEM_size;
   logic        MEM_signext;
   logic [31:0] MEM_memout;
   logic        mem_stall;
   logic        mem_misalign;

   int tests_run;
   int tests_failed;

   mem_access_unit #(.DEPTH(1024), .LATENCY(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .MEM_aluout    (MEM_aluout),
      .MEM_writedata (MEM_writedata),
      .MEM_memread   (MEM_memread),
      .MEM_memwrite  (MEM_memwrite),
      .MEM_size      (MEM_size),
      .MEM_signext   (MEM_signext),
      .MEM_memout    (MEM_memout),
      .mem_stall     (mem_stall),
      .mem_misalign  (mem_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive requests just after the rising edge so the DUT sees them settled.
   task automatic drive_idle();
      MEM_memread   = 1'b0;
      MEM_memwrite  = 1'b0;
      MEM_aluout    = 32'h0;
      MEM_writedata = 32'h0;
      MEM_size      = 2'b10;
      MEM_signext   = 1'b0;
   endtask

   // One LATENCY=2 access: samples stall in the request cycle and stall,
   // data and misalign in the completion cycle, then releases the request.
   task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic se, input logic [31:0] addr,
                            input logic [31:0] wd, output logic st1,
                            output logic st2, output logic mis,
                            output logic [31:0] dout);
      @(posedge clk); #1;
      MEM_memread   = rd;
      MEM_memwrite  = wr;
      MEM_size      = sz;
      MEM_signext   = se;
      MEM_aluout    = addr;
      MEM_writedata = wd;
      @(negedge clk);
      st1 = mem_stall;
      @(posedge clk); #1;
      @(negedge clk);
      st2  = mem_stall;
      mis  = mem_misalign;
      dout = MEM_memout;
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (mem_stall !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_stall: got %b expected 0", mem_stall);
      end
      tests_run++;
      if (MEM_memout !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_memout: got %h expected 00000000", MEM_memout);
      end
      tests_run++;
      if (mem_misalign !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_misalign: got %b expected 0", mem_misalign);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_word();
      logic s1, s2, m;
      logic [31:0] d;
      do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, s1, s2, m, d);
      tests_run++;
      if (s1 !== 1'b1 || s2 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL sw_stall: got %b%b expected 10", s1, s2);
      end
      tests_run++;
      if (d !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL sw_memout: got %h expected 00000000", d);
      end
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, s1, s2, m, d);
      tests_run++;
      if (s1 !== 1'b1 || s2 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL lw_stall: got %b%b expected 10", s1, s2);
      end
      tests_run++;
      if (d !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("[TB] FAIL lw_data: got %h expected deadbeef", d);
      end
      @(negedge clk);
      tests_run++;
      if (mem_stall !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL idle_stall: got %b expected 0", mem_stall);
      end
   endtask

   task automatic test_subword();
      logic s1, s2, m;
      logic [31:0] d;
      do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, s1, s2, m, d);
      tests_run++;
      if (d !== 32'hFFFFFFDE) begin
         tests_failed++;
         $display("[TB] FAIL lb_13: got %h expected ffffffde", d);
      end
      do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, s1, s2, m, d);
      tests_run++;
      if (d !== 32'h000000DE) begin
         tests_failed++;
         $display("[TB] FAIL lbu_13: got %h expected 000000de", d);
      end
      do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, s1, s2, m, d);
      tests_run++;
      if (d !== 32'hFFFFBEEF) begin
         tests_failed++;
         $display("[TB] FAIL lh_10: got %h expected ffffbeef", d);
      end
      do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, s1, s2, m, d);
      tests_run++;
      if (d !== 32'h0000DEAD) begin
         tests_failed++;
         $display("[TB] FAIL lhu_12: got %h expected 0000dead", d);
      end
      do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, s1, s2, m, d);
      tests_run++;
      if (d !== 32'hFFFFFFEF) begin
         tests_failed++;
         $display("[TB] FAIL lb_10: got %h expected ffffffef", d);
      end
   endtask

   task automatic test_byte_store();
      logic s1, s2, m;
      logic [31:0] d;
      do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000005A, s1, s2, m, d);
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, s1, s2, m, d);
      tests_run++;
      if (d !== 32'hDEAD5AEF) begin
         tests_failed++;
         $display("[TB] FAIL sb_merge: got %h expected dead5aef", d);
      end
      do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, s1, s2, m, d);
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, s1, s2, m, d);
      tests_run++;
      if (d !== 32'h12345AEF) begin
         tests_failed++;
         $display("[TB] FAIL sh_merge: got %h expected 12345aef", d);
      end
   endtask

   task automatic test_read_write_both();
      logic s1, s2, m;
      logic [31:0] d;
      do_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, s1, s2, m, d);
      tests_run++;
      if (d !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL rw_memout: got %h expected 00000000", d);
      end
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, s1, s2, m, d);
      tests_run++;
      if (d !== 32'h11223344) begin
         tests_failed++;
         $display("[TB] FAIL rw_stored: got %h expected 11223344", d);
      end
   endtask

   task automatic test_reset_mid();
      logic s1, s2, m;
      logic [31:0] d;
      @(posedge clk); #1;
      MEM_memwrite  = 1'b1;
      MEM_size      = 2'b10;
      MEM_aluout    = 32'h20;
      MEM_writedata = 32'h12345678;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      drive_idle();
      @(negedge clk);
      tests_run++;
      if (mem_stall !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rst_mid_stall: got %b expected 0", mem_stall);
      end
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, s1, s2, m, d);
      tests_run++;
      if (d !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL rst_mid_ram: got %h expected 00000000", d);
      end
   endtask

   task automatic test_wrap();
      logic s1, s2, m;
      logic [31:0] d;
      do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'hCAFEF00D, s1, s2, m, d);
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000, 32'h0, s1, s2, m, d);
      tests_run++;
      if (d !== 32'hCAFEF00D) begin
         tests_failed++;
         $display("[TB] FAIL wrap: got %h expected cafef00d", d);
      end
   endtask

   task automatic test_misalign();
      logic s1, s2, m;
      logic [31:0] d;
      logic        exp_mis;
      logic [31:0] exp_word;
`ifdef MEM_MISALIGN_TRAP_EN
      exp_mis  = 1'b1;
      exp_word = 32'h0;
`else
      exp_mis  = 1'b0;
      exp_word = 32'hA5C3_0F96;
`endif
      do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hA5C3_0F96, s1, s2, m, d);
      tests_run++;
      if (m !== exp_mis) begin
         tests_failed++;
         $display("[TB] FAIL misalign_flag: got %b expected %b", m, exp_mis);
      end
      tests_run++;
      if (s1 !== 1'b1 || s2 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL misalign_stall: got %b%b expected 10", s1, s2);
      end
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, s1, s2, m, d);
      tests_run++;
      if (d !== exp_word) begin
         tests_failed++;
         $display("[TB] FAIL misalign_ram: got %h expected %h", d, exp_word);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      drive_idle();
      test_reset();
      test_word();
      test_subword();
      test_byte_store();
      test_read_write_both();
      test_reset_mid();
      test_wrap();
      test_misalign();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
